// File: rtl/tilelink_uart_tx_pkg.sv
// TileLink-UL channel payloads and opcodes shared by the serial TX peripheral and its bench.
package tilelink_uart_tx_pkg;

  localparam logic [2:0] op_put_full          = 3'd0;
  localparam logic [2:0] op_put_partial       = 3'd1;
  localparam logic [2:0] op_get               = 3'd4;
  localparam logic [2:0] op_access_ack        = 3'd0;
  localparam logic [2:0] op_access_ack_data   = 3'd1;

  typedef struct packed {
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_valid;
  } tilelink_a;

  typedef struct packed {
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
  } tilelink_d;

endpackage

// File: rtl/tilelink_uart_tx.sv
// TileLink-UL serial transmitter: byte writes fill a small FIFO drained as 8N1 frames;
// reads return status and a saturating dropped-byte count.
module tilelink_uart_tx
  import tilelink_uart_tx_pkg::*;
#(
  parameter logic [31:0] addr_mask      = 32'hF0000000,
  parameter logic [31:0] addr_tag       = 32'hC0000000,
  parameter int unsigned clocks_per_bit = 16,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic      clock,
  input  logic      reset_in,
  input  tilelink_a tick_tla,
  output tilelink_d bus_tld,
  output logic      ser_tx,
  output logic      tx_busy
);

  localparam int unsigned ptr_w   = $clog2(fifo_depth);
  localparam int unsigned count_w = ptr_w + 1;
  localparam int unsigned cnt_w   = $clog2(clocks_per_bit);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(clocks_per_bit - 1);

  typedef enum logic [1:0] {
    st_idle,
    st_start,
    st_data,
    st_stop
  } tx_state_t;

  logic                hit;
  logic                is_get;
  logic                is_put;
  logic [1:0]          offset;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [ptr_w-1:0]    wr_ptr_q;
  logic [ptr_w-1:0]    rd_ptr_q;
  logic [count_w-1:0]  count_q;
  logic [7:0]          mem_q [fifo_depth];
  logic [15:0]         drop_cnt_q;
  logic [31:0]         rd_data;

  tx_state_t           state_q, state_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                ser_q, ser_d;
  logic                bit_done;

  logic                d_valid_q;
  logic [2:0]          d_opcode_q;
  logic [31:0]         d_data_q;

  logic                unused_tla;

  // Request decode
  assign hit      = tick_tla.a_valid && ((tick_tla.a_address & addr_mask) == addr_tag);
  assign is_get   = tick_tla.a_opcode == op_get;
  assign is_put   = (tick_tla.a_opcode == op_put_full) || (tick_tla.a_opcode == op_put_partial);
  assign offset   = tick_tla.a_address[3:2];
  assign push_req = hit && is_put && (offset == 2'd0) && tick_tla.a_mask[0];

  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == count_w'(fifo_depth);
  // A full FIFO still takes the byte when the transmitter frees a slot in the same cycle
  assign push       = push_req && (!fifo_full || pop);

  assign unused_tla = ^{tick_tla.a_param, tick_tla.a_size, tick_tla.a_source,
                        tick_tla.a_address, tick_tla.a_mask[3:1], tick_tla.a_data[31:8]};

  always_comb begin
    rd_data = '0;
    case (offset)
      2'd0:    rd_data = {24'd0, 5'(count_q), state_q != st_idle, fifo_full, fifo_empty};
      2'd1:    rd_data = {16'd0, drop_cnt_q};
      default: rd_data = '0;
    endcase
  end

  // FIFO pointers, occupancy and drop counter
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_w'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + count_w'(1);
        2'b01:   count_q <= count_q - count_w'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && !push && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tick_tla.a_data[7:0];
  end

  // Transmitter next state; the line level is derived from the next state so it is registered
  assign bit_done = cnt_q == cnt_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    ser_d   = 1'b1;
    case (state_q)
      st_idle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = st_start;
        end
      end
      st_start: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = st_data;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      st_data: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) state_d = st_stop;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      st_stop: begin
        if (bit_done) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = st_start;
          end else begin
            state_d = st_idle;
          end
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      default: state_d = st_idle;
    endcase
    case (state_d)
      st_start: ser_d = 1'b0;
      st_data:  ser_d = shift_d[0];
      default:  ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
    end
  end

  // Response channel, one cycle after the request
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_data_q   <= '0;
    end else begin
      d_valid_q  <= hit;
      d_opcode_q <= (hit && is_get) ? op_access_ack_data : op_access_ack;
      d_data_q   <= (hit && is_get) ? rd_data : '0;
    end
  end

  always_comb begin
    bus_tld          = '0;
    bus_tld.d_opcode = d_opcode_q;
    bus_tld.d_data   = d_data_q;
    bus_tld.d_valid  = d_valid_q;
  end

  assign ser_tx  = ser_q;
  assign tx_busy = (state_q != st_idle) || !fifo_empty;

endmodule

// File: doc/tilelink_uart_tx.md
Name: tilelink_uart_tx

Overview:
- TileLink-UL responder peripheral on the data bus at tag 0xC.
- Accepts byte writes from the core into a small TX FIFO and serializes them as 8N1 on a single output pin.
- Returns a status word and a dropped-byte count on reads.
- Fills the serial slot in the top-level data-bus decode. The top level muxes bus_tld.d_data into the core read path whenever the serial chip-select is registered.

Parameters:
- addr_mask, 32'hF0000000, bits of a_address compared for select.
- addr_tag, 32'hC0000000, value the masked address must equal.
- clocks_per_bit, 16, clock cycles per serial bit; legal range 2..65535.
- fifo_depth, 4, TX FIFO entries; power of two, range 2..16.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- tick_tla  in  tilelink_a  request channel from the core bus. Uses a_opcode, a_address, a_mask, a_data, a_valid.
- bus_tld  out  tilelink_d  registered response channel. Drives d_opcode, d_data, d_valid; all other fields are 0.
- ser_tx  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Select: hit = tick_tla.a_valid && ((a_address & addr_mask) == addr_tag). The device is always ready and never stalls.
- Register map (offset = a_address[3:2]):
  - 0 = TXDATA (write) / STATUS (read).
  - 1 = DROPCNT (read-only).
  - 2, 3 reserved: read 0, writes ignored.
- Response timing: exactly one cycle after a hit, d_valid=1.
  - Get → d_opcode=AccessAckData.
  - PutFullData/PutPartialData → d_opcode=AccessAck, d_data=0.
  - No hit → d_valid=0, d_data=0 next cycle.
- Read data is sampled in the request cycle, before that cycle's push/pop takes effect.
- STATUS layout:
  - [0] fifo_empty, [1] fifo_full, [2] line_busy (FSM not IDLE).
  - [7:3] fifo_count (0..fifo_depth).
  - [31:8] = 0.
- DROPCNT: [15:0] saturating dropped-write count, [31:16] = 0.
- Push: a write hit at offset 0 with a_mask[0]=1 pushes a_data[7:0].
  - a_mask[0]=0: no push, still acked.
- Push is accepted when !full, or when full and the FSM pops in the same cycle.
  - Otherwise the byte is discarded and DROPCNT increments, saturating at 16'hFFFF.
- FIFO: circular buffer with log2(fifo_depth)-bit read/write pointers (wrap naturally) and a separate count of width log2(fifo_depth)+1.
  - Simultaneous push and pop leaves count unchanged.
- TX FSM states, with cnt counting 0..clocks_per_bit-1 per bit:
  - IDLE: ser_tx=1. If FIFO non-empty, pop head into shift register, cnt=0 → START.
  - START: ser_tx=0 for clocks_per_bit cycles → DATA with bit index 0.
  - DATA: ser_tx=shift[0], LSB first. After each clocks_per_bit cycles shift right and index+1. After index 7 completes → STOP.
  - STOP: ser_tx=1 for clocks_per_bit cycles. Then, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); else → IDLE.
- Frame length: exactly 10*clocks_per_bit cycles.
- Latency: a write in cycle N pushes at edge N, IDLE pops at edge N+1, and ser_tx falls in cycle N+2 (empty FIFO, idle line).
- ser_tx is registered: it changes only on clock edges and is glitch-free.
- tx_busy = (state != IDLE) || !fifo_empty, combinational from registers.
- Reset (asynchronous, any time including mid-frame):
  - ser_tx=1 immediately; state=IDLE.
  - FIFO pointers and count = 0; DROPCNT = 0.
  - bus_tld all zero (d_valid=0); tx_busy=0.
- A partial frame is abandoned with no completion.
- After reset deasserts, the first hit is acked one cycle later as normal.

Test Plan:
- clocks_per_bit=4, write 0x55 to 0xC0000000, mask=4'b0001 → AccessAck next cycle; ser_tx falls 2 cycles after the request. Line sequence is 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each held 4 cycles; 40 cycles total; then tx_busy=0.
- fifo_depth=4, write 6 bytes 0x01..0x06 on consecutive cycles while the line is idle. The first is popped immediately, so 0x01..0x05 are accepted and 0x06 is dropped. DROPCNT read returns 1. Frames 0x01..0x05 go out back-to-back with no idle gap.
- Full FIFO and FSM in STOP popping on the same cycle as a write → byte accepted, count stays 4, DROPCNT unchanged.
- Read STATUS with 2 bytes queued and a frame active → d_data=32'h00000014 (count=2, busy=1, full=0, empty=0), AccessAckData one cycle later. Read at 0x80000000 → no d_valid.
- Write with mask=4'b0010 → AccessAck, fifo_count unchanged, no frame. Read of offset 0xC → d_data=0.
- Assert reset_in asynchronously mid-DATA bit 3 → ser_tx=1 within the same cycle, STATUS reads 32'h00000001 after release, DROPCNT=0. A new write then produces a clean full frame.
